uart_rx: RTL
============

Name: uart_rx

Overview:
- Receive side of the FTDI serial link: samples `serial_rxd` and deframes 8N1 bytes (8 data bits, no parity, 1 stop bit) by default.
- Presents each received byte on a valid/ready holding register for downstream logic, e.g. an LED-colour command parser.
- Mirrors the board's transmit path: runs from the 12 MHz internal oscillator clock, with mid-bit majority-vote sampling and framing/overrun error reporting.

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, (CLK_HZ+BAUD/2)/BAUD (=104 at the defaults), clocks per bit period. Derived; must be ≥ 8.

Ports:
- clk  input  1  system clock (12 MHz from SB_HFOSC).
- rst  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial line; idle high.
- rx_data  output  8  received byte, LSB first on the wire.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready on a clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a byte completed while rx_valid was still high; cleared only by rst.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - rx_data = 8'h00, rx_valid = 0, frame_err = 0, overrun = 0.
  - Both synchronizer flops = 1 (line idle), so no false start bit at reset release.
  - FSM = IDLE; bit counter and baud counter = 0.
- Input path: two-flop synchronizer on rxd into rxd_s. All decisions use rxd_s.
- Sampling: a baud counter counts 0..CLKS_PER_BIT-1. Each bit value is the majority of rxd_s at counts M-1, M and M+1, where M = CLKS_PER_BIT/2.
- FSM:
  - IDLE → START on a falling edge of rxd_s (1 then 0). Baud counter is set to 0.
  - START: at count M+1, if the majority is 1 (glitch) → IDLE with no output. Else continue to the end of the bit period → DATA, bit index 0.
  - DATA: shift the majority bit into the MSB of the shift register, LSB arrives first. After bit index 7 → STOP (or PARITY when the macro is set).
  - STOP: at count M+1, evaluate the sample.
    - Sample 1: load the byte into rx_data and set rx_valid. If rx_valid was already high and not being accepted in that cycle, rx_data is overwritten with the new byte and overrun is set.
    - Sample 0: pulse frame_err for one cycle. The byte is discarded and rx_valid is unchanged.
    - Either way → IDLE immediately at count M+1. Early return allows a new start edge within half a bit, tolerating ±4% baud mismatch.
- Handshake:
  - rx_valid clears on the edge where rx_valid && rx_ready.
  - If acceptance and a new load happen in the same cycle, the load wins: rx_valid stays 1, rx_data takes the new byte, no overrun.
- Line held low (break):
  - One frame_err pulse.
  - FSM stays in IDLE until rxd_s returns high, because a falling edge is required to start.
- Reset mid-frame: the partial byte is dropped, the FSM returns to IDLE, and the next falling edge is treated as a start bit.
- Latency: rx_valid rises 2 (sync) + ~9.5 bit periods after the start edge, i.e. ~990 clocks at the defaults.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit.
  - Adds output `parity_err` (1 bit, one-cycle pulse, reset 0). It pulses when the XOR of the data bits and the parity bit is 1.
  - On a parity error the byte is discarded; the stop bit is still checked.
- Undefined: no PARITY state, no parity_err port, 8N1 only.

Decomposition:
- Package uart_pkg holds:
  - The FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - Function clks_per_bit(CLK_HZ, BAUD).
  - Constant UART_DATA_BITS = 8.
  The future uart_tx shares this package.
- One natural sub-module, sync2: a generic two-flop synchronizer with a reset value parameter, here 1.

Test Plan:
- Defaults: send 8'hA5 (8N1) at 115200 with rx_ready = 1 → rx_valid pulses once, rx_data = 8'hA5, frame_err = 0, overrun = 0.
- Send 8'h3C with a 1-clock low glitch on rxd during IDLE → no rx_valid. Then a clean 8'h3C → rx_data = 8'h3C.
- Send 8'h55 with the stop bit forced 0 → frame_err pulses once, rx_valid stays 0. The following clean 8'h0F is received correctly.
- rx_ready = 0, send 8'h11 then 8'h22 → after the second byte rx_data = 8'h22, rx_valid = 1, overrun = 1. Assert rst → overrun = 0, rx_valid = 0.
- Transmitter at 110400 baud (−4.2%) and 120000 baud (+4.2%), sending 8'h00, 8'hFF, 8'h81 back-to-back → all three bytes received correctly.
- rst asserted for 1 cycle during bit 4 of 8'hF0, then 8'h99 sent → only 8'h99 is reported. With UART_RX_PARITY_EN, 8'h99 sent with parity bit 1 → parity_err pulses, no rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared definitions for the UART receive and transmit paths.
//   uart_state_t   : deframing FSM states (PARITY only used when parity enabled)
//   clks_per_bit() : rounded clocks per bit period for a given clock and baud
//   UART_DATA_BITS : data bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2 -- generic two-flop synchronizer with a configurable reset value.
//   clk : destination clock
//   rst : synchronous, active-high reset (both flops load RESET_VAL)
//   d   : asynchronous input
//   q   : synchronized output
// -----------------------------------------------------------------------------
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- serial receiver, 8N1 by default, with majority-vote mid-bit
// sampling, a valid/ready holding register and framing/overrun reporting.
//
// Ports:
//   clk        : system clock (12 MHz)
//   rst        : synchronous, active-high reset
//   rxd        : asynchronous serial line, idle high
//   rx_data    : received byte (LSB first on the wire)
//   rx_valid   : rx_data holds an unconsumed byte
//   rx_ready   : consumer takes the byte on a clk edge with rx_valid high
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : sticky, a byte completed while rx_valid was still high
//   parity_err : one-cycle pulse, even parity check failed
//                (only present when UART_RX_PARITY_EN is defined)
//
// Build option: define UART_RX_PARITY_EN for 8E1 framing (adds PARITY state
// and the parity_err port). Default build is 8N1.
//
// CLKS_PER_BIT must be >= 8 so the three vote samples fit inside a bit.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a falling edge on the synchronized line
// START  | validating the start bit; a high majority is a glitch
// DATA   | shifting in data bits, LSB first
// PARITY | sampling the even-parity bit (parity build only)
// STOP   | sampling the stop bit; leaves at mid-bit to catch early starts
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = 12000000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rxd,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic                      frame_err,
   output logic                      overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic                      parity_err
`endif
);

   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int BW  = $clog2(UART_DATA_BITS);
   localparam int MID = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(MID - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(MID);
   localparam logic [CW-1:0] CNT_POST = CW'(MID + 1);
   localparam logic [BW-1:0] IDX_LAST = BW'(UART_DATA_BITS - 1);

   logic                      rxd_s;
   logic                      rxd_q;
   uart_state_t               state;
   logic [CW-1:0]             cnt;
   logic [BW-1:0]             bit_idx;
   logic [UART_DATA_BITS-1:0] shreg;
   logic [1:0]                vote;
   logic                      maj;
   logic                      accept;
`ifdef UART_RX_PARITY_EN
   logic                      par_bad;
`endif

   // Reset value 1 keeps the line "idle" so reset release cannot fake a start.
   sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxd_s)
   );

   // vote[0]/vote[1] hold the samples from counts M-1 and M; the live line
   // value at count M+1 is the third vote.
   assign maj    = (vote[0] & vote[1]) | (vote[0] & rxd_s) | (vote[1] & rxd_s);
   assign accept = rx_valid & rx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         vote      <= '0;
         rxd_q     <= 1'b1;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         rxd_q     <= rxd_s;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (accept) begin
            rx_valid <= 1'b0;
         end

         if (cnt == CNT_PRE) begin
            vote[0] <= rxd_s;
         end
         if (cnt == CNT_MID) begin
            vote[1] <= rxd_s;
         end

         if (state == IDLE) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end

         case (state)
            IDLE: begin
               // A falling edge is required, so a held-low line never restarts.
               if (rxd_q && !rxd_s) begin
                  state <= START;
               end
            end

            START: begin
               if (cnt == CNT_POST && maj) begin
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  state   <= DATA;
                  bit_idx <= '0;
               end
            end

            DATA: begin
               if (cnt == CNT_POST) begin
                  shreg <= {maj, shreg[UART_DATA_BITS-1:1]};
               end
               if (cnt == CNT_LAST) begin
                  if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + BW'(1);
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == CNT_POST) begin
                  par_bad    <= ^{shreg, maj};
                  parity_err <= ^{shreg, maj};
               end
               if (cnt == CNT_LAST) begin
                  state <= STOP;
               end
            end
`endif

            STOP: begin
               if (cnt == CNT_POST) begin
                  state <= IDLE;
                  if (!maj) begin
                     frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (!par_bad) begin
`else
                  end else begin
`endif
                     // A load overrides a same-cycle acceptance.
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                     if (rx_valid && !rx_ready) begin
                        overrun <= 1'b1;
                     end
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
